// File: rtl/dpram_access_ctrl.sv
// dpram_access_ctrl
//   Front-end controller for a dual-port RAM. It arbitrates two write clients
//   onto the single RAM write port with round-robin priority and passes one
//   read client onto the RAM read port.
//
//   A read that targets the address of the write being granted in the same
//   cycle is stalled. The write lands first, so the read sees the new data.
//   A valid strobe is carried alongside the RAM read latency so the read data
//   comes back marked.
//
//   Ports:
//     clk, rst                 clock; asynchronous active-low reset
//     w0_* / w1_*              write clients: req, addr, data in; gnt out (comb)
//     r_req, r_addr, r_gnt     read client request/grant (grant is comb)
//     r_valid, r_data          read return, RD_LAT+1 cycles after the grant
//     ram_wr_en/addr/data_in   registered RAM write port
//     ram_rd_en/addr           registered RAM read port
//     ram_data_out             RAM read data
//     stall_cnt                saturating count of collision-stalled read cycles
`timescale 1ns/1ps
module dpram_access_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w0_req,
  input  logic [ADDR_W-1:0] w0_addr,
  input  logic [DATA_W-1:0] w0_data,
  output logic              w0_gnt,
  input  logic              w1_req,
  input  logic [ADDR_W-1:0] w1_addr,
  input  logic [DATA_W-1:0] w1_data,
  output logic              w1_gnt,
  input  logic              r_req,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              r_gnt,
  output logic              r_valid,
  output logic [DATA_W-1:0] r_data,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic [7:0]        stall_cnt
);

  // rr_q = 0: client 0 wins a tie; rr_q = 1: client 1 wins a tie.
  logic              rr_q, rr_d;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]        stall_q, stall_d;
  logic [RD_LAT-1:0] vpipe_q;

  logic              g0, g1, wr_grant, collide, rd_grant;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  always_comb begin
    g0       = w0_req & (~w1_req | ~rr_q);
    g1       = w1_req & (~w0_req |  rr_q);
    wr_grant = g0 | g1;
    sel_addr = g1 ? w1_addr : w0_addr;
    sel_data = g1 ? w1_data : w0_data;
    // The write always wins a same-address clash; the read retries next cycle.
    collide  = wr_grant & (sel_addr == r_addr);
    rd_grant = r_req & ~collide;

    rr_d = rr_q;
    if (g0) begin
      rr_d = 1'b1;
    end else if (g1) begin
      rr_d = 1'b0;
    end

    wr_addr_d = wr_grant ? sel_addr : wr_addr_q;
    wr_data_d = wr_grant ? sel_data : wr_data_q;
    rd_addr_d = rd_grant ? r_addr   : rd_addr_q;

    stall_d = stall_q;
    if (r_req && collide && (stall_q != 8'hFF)) begin
      stall_d = stall_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q      <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      stall_q   <= 8'd0;
    end else begin
      rr_q      <= rr_d;
      wr_en_q   <= wr_grant;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_en_q   <= rd_grant;
      rd_addr_q <= rd_addr_d;
      stall_q   <= stall_d;
    end
  end

  // Valid strobe follows ram_rd_en through RD_LAT stages, matching the RAM.
  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_vpipe
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vpipe_q[gi] <= 1'b0;
        end else if (gi == 0) begin
          vpipe_q[gi] <= rd_en_q;
        end else begin
          vpipe_q[gi] <= vpipe_q[(gi == 0) ? 0 : gi-1];
        end
      end
    end
  endgenerate

  assign w0_gnt      = g0;
  assign w1_gnt      = g1;
  assign r_gnt       = rd_grant;
  assign ram_wr_en   = wr_en_q;
  assign ram_wr_addr = wr_addr_q;
  assign ram_data_in = wr_data_q;
  assign ram_rd_en   = rd_en_q;
  assign ram_rd_addr = rd_addr_q;
  assign stall_cnt   = stall_q;
  assign r_valid     = vpipe_q[RD_LAT-1];
  // Zeroed outside the valid strobe so idle and reset states show clean zeros.
  assign r_data      = r_valid ? ram_data_out : '0;

endmodule

// File: tb/tb_dpram_access_ctrl.sv
`timescale 1ns/1ps
module tb_dpram_access_ctrl;

  logic       clk, rst;
  logic       w0_req, w1_req, r_req;
  logic [7:0] w0_addr, w0_data, w1_addr, w1_data, r_addr;
  logic       w0_gnt, w1_gnt, r_gnt, r_valid;
  logic [7:0] r_data;
  logic       ram_wr_en, ram_rd_en;
  logic [7:0] ram_wr_addr, ram_data_in, ram_rd_addr, ram_data_out;
  logic [7:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  dpram_access_ctrl #(.DATA_W(8), .ADDR_W(8), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .w0_req(w0_req), .w0_addr(w0_addr), .w0_data(w0_data), .w0_gnt(w0_gnt),
    .w1_req(w1_req), .w1_addr(w1_addr), .w1_data(w1_data), .w1_gnt(w1_gnt),
    .r_req(r_req), .r_addr(r_addr), .r_gnt(r_gnt),
    .r_valid(r_valid), .r_data(r_data),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_data_in(ram_data_in),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_data_out(ram_data_out),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model, 1-cycle read latency. Unwritten locations read as addr ^ 0x3C.
  logic [7:0]   mem [256];
  logic [255:0] written;
  always @(posedge clk) begin
    if (!rst) begin
      written <= '0;
    end else begin
      if (ram_wr_en) begin
        mem[ram_wr_addr]     <= ram_data_in;
        written[ram_wr_addr] <= 1'b1;
      end
      if (ram_rd_en) begin
        ram_data_out <= written[ram_rd_addr] ? mem[ram_rd_addr] : (ram_rd_addr ^ 8'h3C);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Returns 1 ns after a rising edge; inputs are driven here, checks 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] rd_exp [4];

  initial begin
    rd_exp[0] = 8'h3C; rd_exp[1] = 8'h3D; rd_exp[2] = 8'h3E; rd_exp[3] = 8'h3F;
    rst = 1'b0;
    w0_req = 0; w1_req = 0; r_req = 0;
    w0_addr = 0; w0_data = 0; w1_addr = 0; w1_data = 0; r_addr = 0;
    ram_data_out = 0;
    repeat (3) step();
    rst = 1'b1;
    #1;
    chk("reset ram_wr_en", ram_wr_en, 1'b0);
    chk("reset ram_rd_en", ram_rd_en, 1'b0);
    chk("reset r_valid", r_valid, 1'b0);
    chk("reset stall_cnt", stall_cnt, 8'd0);
    chk("reset ram_wr_addr", ram_wr_addr, 8'd0);

    // 1: single w0 write
    step();
    w0_req = 1; w0_addr = 8'h10; w0_data = 8'hA5;
    #1;
    chk("t1 w0_gnt", w0_gnt, 1'b1);
    chk("t1 w1_gnt", w1_gnt, 1'b0);
    step();
    w0_req = 0;
    #1;
    chk("t1 ram_wr_en", ram_wr_en, 1'b1);
    chk("t1 ram_wr_addr", ram_wr_addr, 8'h10);
    chk("t1 ram_data_in", ram_data_in, 8'hA5);
    step();
    #1;
    chk("t1 ram_wr_en idle", ram_wr_en, 1'b0);

    // 3: w1 write collides with read of the same address (also hands priority back to w0)
    w1_req = 1; w1_addr = 8'h20; w1_data = 8'h5A; r_req = 1; r_addr = 8'h20;
    #1;
    chk("t3 w1_gnt", w1_gnt, 1'b1);
    chk("t3 r_gnt stalled", r_gnt, 1'b0);
    step();
    w1_req = 0;
    #1;
    chk("t3 stall_cnt", stall_cnt, 8'd1);
    chk("t3 r_gnt retry", r_gnt, 1'b1);
    chk("t3 ram_wr_addr", ram_wr_addr, 8'h20);
    step();
    r_req = 0;
    #1;
    chk("t3 ram_rd_en", ram_rd_en, 1'b1);
    chk("t3 ram_rd_addr", ram_rd_addr, 8'h20);
    chk("t3 r_valid early", r_valid, 1'b0);
    step();
    #1;
    chk("t3 r_valid", r_valid, 1'b1);
    chk("t3 r_data", r_data, 8'h5A);
    step();
    #1;
    chk("t3 r_valid end", r_valid, 1'b0);

    // 2: both writers for 6 cycles -> w0,w1,w0,w1,w0,w1
    w0_req = 1; w0_addr = 8'h30; w0_data = 8'hC0;
    w1_req = 1; w1_addr = 8'h31; w1_data = 8'hC1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("t2 w0_gnt c%0d", k), w0_gnt, (k % 2 == 0) ? 1'b1 : 1'b0);
      chk($sformatf("t2 w1_gnt c%0d", k), w1_gnt, (k % 2 == 1) ? 1'b1 : 1'b0);
      if (k > 0) chk($sformatf("t2 ram_data_in c%0d", k), ram_data_in, (k % 2 == 1) ? 8'hC0 : 8'hC1);
      step();
    end
    w0_req = 0; w1_req = 0;
    #1;
    chk("t2 last ram_data_in", ram_data_in, 8'hC1);
    chk("t2 last ram_wr_addr", ram_wr_addr, 8'h31);

    // 4: back-to-back reads 0..3; a write to another address must not stall them
    step();
    for (int c = 0; c < 7; c++) begin
      r_req = (c < 4); r_addr = c[7:0];
      w0_req = (c == 0); w0_addr = 8'h50; w0_data = 8'h77;
      #1;
      if (c < 4) chk($sformatf("t4 r_gnt c%0d", c), r_gnt, 1'b1);
      if (c >= 2 && c < 6) begin
        chk($sformatf("t4 r_valid c%0d", c), r_valid, 1'b1);
        chk($sformatf("t4 r_data c%0d", c), r_data, rd_exp[c-2]);
      end else begin
        chk($sformatf("t4 r_valid idle c%0d", c), r_valid, 1'b0);
      end
      step();
    end
    r_req = 0; w0_req = 0;

    // 5: reset with a write and reads in flight
    w0_req = 1; w0_addr = 8'h60; w0_data = 8'h66; r_req = 1; r_addr = 8'h00;
    step();
    w0_req = 0; r_addr = 8'h01;
    #1;
    chk("t5 pre ram_wr_en", ram_wr_en, 1'b1);
    #2;
    rst = 1'b0; r_req = 0;
    #1;
    chk("t5 rst ram_wr_en", ram_wr_en, 1'b0);
    chk("t5 rst ram_rd_en", ram_rd_en, 1'b0);
    chk("t5 rst ram_wr_addr", ram_wr_addr, 8'h00);
    chk("t5 rst ram_data_in", ram_data_in, 8'h00);
    chk("t5 rst ram_rd_addr", ram_rd_addr, 8'h00);
    chk("t5 rst r_valid", r_valid, 1'b0);
    chk("t5 rst r_data", r_data, 8'h00);
    chk("t5 rst stall_cnt", stall_cnt, 8'd0);
    step();
    step();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("t5 no r_valid c%0d", c), r_valid, 1'b0);
      step();
    end
    w0_req = 1; w0_addr = 8'h61; w0_data = 8'h11;
    w1_req = 1; w1_addr = 8'h62; w1_data = 8'h22;
    #1;
    chk("t5 first w0_gnt", w0_gnt, 1'b1);
    chk("t5 first w1_gnt", w1_gnt, 1'b0);
    step();
    w0_req = 0; w1_req = 0;
    #1;
    chk("t5 ram_wr_addr", ram_wr_addr, 8'h61);
    step();

    // 6: continuous collision -> stall_cnt saturates at 255
    w0_req = 1; w0_addr = 8'h70; w0_data = 8'h07; r_req = 1; r_addr = 8'h70;
    #1;
    chk("t6 r_gnt stalled", r_gnt, 1'b0);
    for (int i = 1; i <= 300; i++) begin
      step();
      if (i == 254 || i == 255 || i == 300) begin
        #1;
        chk($sformatf("t6 stall_cnt after %0d", i), stall_cnt, (i >= 255) ? 8'd255 : i[7:0]);
      end
    end
    w0_req = 0; r_req = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
